// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the encrypt and decrypt blocks: FSM encoding,
// S-box tables, GF(2^8) helpers and the forward/inverse key-schedule steps.
package aes_pkg;

  localparam int AES128_NR = 10;

  typedef enum logic [2:0] {
    IDLE,
    KEY_EXP,
    INIT_ARK,
    ROUND,
    FINAL
  } aes_state_e;

  // Tables are listed from entry 0 down, so entry b sits at packed index ~b.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [255:0][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[~b];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[~b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Byte idx of a column-major state; byte 0 lives in bits [127:120].
  function automatic logic [7:0] get_byte(input logic [127:0] s, input int idx);
    return s[127-8*idx -: 8];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] forward_next(input logic [127:0] key, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = key;
    w0 = w0 ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undoes forward_next: each earlier word is recovered from its successor.
  function automatic logic [127:0] inverse_next(input logic [127:0] key, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    logic [31:0] w0, w1, w2, w3;
    {n0, n1, n2, n3} = key;
    w3 = n3 ^ n2;
    w2 = n2 ^ n1;
    w1 = n1 ^ n0;
    w0 = n0 ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES decryption round: InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless pi_skip_mix is set (last round).
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] pi_in,
  input  logic [127:0] pi_key,
  input  logic         pi_skip_mix,
  output logic [127:0] po_out
);

  logic [127:0] ark;
  logic [127:0] mixed;

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  // Row r of column c comes from column (c - r) mod 4 before substitution.
  always_comb begin
    ark = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        ark[127-8*(4*c+r) -: 8] = inv_sbox(get_byte(pi_in, 4*((c - r + 4) % 4) + r))
                                  ^ get_byte(pi_key, 4*c + r);
      end
    end
  end

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = inv_mix_column(ark[127-32*c -: 32]);
    end
  end

  assign po_out = pi_skip_mix ? ark : mixed;

endmodule

// File: rtl/aes_decrypt_block.sv
// Iterative AES-128 decryptor: expands the key forward to round key 10, then
// walks the schedule backwards while running one inverse round per clock.
module aes_decrypt_block
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         pi_clk,
  input  logic         pi_rst_n,
  input  logic         pi_start,
  input  logic [127:0] pi_input_key,
  input  logic [127:0] pi_input_data,
  output logic         po_busy,
  output logic         po_key_phase,
  output logic [3:0]   po_current_round,
  output logic         po_end_of_decryption,
  output logic [127:0] po_out
);

  if (NR != AES128_NR) begin : g_bad_nr
    $error("aes_decrypt_block: NR must be 10 for AES-128");
  end

  localparam logic [3:0] LAST_ROUND = 4'(NR);
  localparam logic [3:0] LAST_EXP   = 4'(NR - 1);

  aes_state_e   state_q, state_d;
  logic [127:0] data_q, data_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] out_q, out_d;
  logic         busy_q, busy_d;
  logic         key_phase_q, key_phase_d;
  logic         done_q, done_d;
  logic [127:0] round_out;

  aes_inv_round u_inv_round (
    .pi_in       (data_q),
    .pi_key      (key_q),
    .pi_skip_mix (state_q == FINAL),
    .po_out      (round_out)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    key_d   = key_q;
    round_d = round_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pi_start) begin
          data_d  = pi_input_data;
          key_d   = pi_input_key;
          round_d = '0;
          state_d = KEY_EXP;
        end
      end
      KEY_EXP: begin
        key_d   = forward_next(key_q, rcon(round_q + 4'd1));
        round_d = round_q + 4'd1;
        if (round_q == LAST_EXP) state_d = INIT_ARK;
      end
      INIT_ARK: begin
        data_d  = data_q ^ key_q;
        key_d   = inverse_next(key_q, rcon(LAST_ROUND));
        round_d = LAST_ROUND - 4'd1;
        state_d = ROUND;
      end
      ROUND: begin
        data_d  = round_out;
        key_d   = inverse_next(key_q, rcon(round_q));
        round_d = round_q - 4'd1;
        if (round_q == 4'd1) state_d = FINAL;
      end
      FINAL: begin
        out_d   = round_out;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Busy trails the state by one cycle so it drops on the same edge done rises.
    busy_d      = (state_q == KEY_EXP) || (state_q == INIT_ARK) || (state_q == ROUND);
    key_phase_d = (state_d == KEY_EXP);
  end

  always_ff @(posedge pi_clk or negedge pi_rst_n) begin
    if (!pi_rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      key_q       <= '0;
      round_q     <= '0;
      out_q       <= '0;
      busy_q      <= 1'b0;
      key_phase_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      key_q       <= key_d;
      round_q     <= round_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
      key_phase_q <= key_phase_d;
      done_q      <= done_d;
    end
  end

  assign po_busy              = busy_q;
  assign po_key_phase         = key_phase_q;
  assign po_current_round     = (state_q == IDLE) ? 4'd0 : round_q;
  assign po_end_of_decryption = done_q;
  assign po_out               = out_q;

endmodule

// File: tb/tb_aes_decrypt_block.sv
// Directed and loopback bench for aes_decrypt_block using FIPS-197 vectors and
// a bench-side AES-128 encryptor for random key/plaintext pairs.
module tb_aes_decrypt_block;
  import aes_pkg::*;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk = 1'b0;
  logic         pi_rst_n;
  logic         pi_start;
  logic [127:0] pi_input_key;
  logic [127:0] pi_input_data;
  logic         po_busy;
  logic         po_key_phase;
  logic [3:0]   po_current_round;
  logic         po_end_of_decryption;
  logic [127:0] po_out;

  int totalChecks = 0;
  int badChecks   = 0;
  int cycleCount  = 0;
  int startCycle  = 0;
  int doneCount   = 0;

  aes_decrypt_block #(.NR(10)) dut (
    .pi_clk               (clk),
    .pi_rst_n             (pi_rst_n),
    .pi_start             (pi_start),
    .pi_input_key         (pi_input_key),
    .pi_input_data        (pi_input_data),
    .po_busy              (po_busy),
    .po_key_phase         (po_key_phase),
    .po_current_round     (po_current_round),
    .po_end_of_decryption (po_end_of_decryption),
    .po_out               (po_out)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Edge counter used to measure latency in whole cycles.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Counts every done pulse so stray or missing completions show up.
  always @(negedge clk) if (po_end_of_decryption) doneCount++;

  // Hard stop in case something wedges outside a bounded wait.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; the following posedge is the start edge E0 and the
  // task returns at the negedge after it with data inputs scrambled.
  task automatic applyStimulus(input logic [127:0] key, input logic [127:0] ct);
    pi_input_key  = key;
    pi_input_data = ct;
    pi_start      = 1'b1;
    @(negedge clk);
    pi_start      = 1'b0;
    pi_input_key  = ~key;
    pi_input_data = ~ct;
    startCycle    = cycleCount;
  endtask

  task automatic waitDone(input string tag, output int latency);
    latency = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (po_end_of_decryption) begin
        latency = cycleCount - startCycle;
        break;
      end
    end
    if (latency < 0) checkOutput({tag, "_timeout"}, 128'd0, 128'd1);
  endtask

  function automatic logic [127:0] aesEncrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] st, rk, tmp;
    logic [7:0]   a0, a1, a2, a3;
    rk = key;
    st = pt ^ rk;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      tmp = '0;
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          tmp[127-8*(4*c+r) -: 8] = sbox(get_byte(st, 4*((c + r) % 4) + r));
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          {a0, a1, a2, a3} = tmp[127-32*c -: 32];
          tmp[127-32*c -: 32] = {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                                 a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                                 a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                                 gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
        end
      end
      rk = forward_next(rk, rcon(4'(rnd)));
      st = tmp ^ rk;
    end
    return st;
  endfunction

  // Main sequence: reset, directed vectors, protocol corner cases, loopback.
  initial begin
    int lat;
    int dc0;
    int firstDone;
    int secondDone;
    int randBad;
    logic holdOk;
    logic [127:0] rk, rp, rc;

    pi_rst_n      = 1'b0;
    pi_start      = 1'b0;
    pi_input_key  = '0;
    pi_input_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_out", po_out, 128'd0);
    checkOutput("rst_busy", 128'(po_busy), 128'd0);
    checkOutput("rst_key_phase", 128'(po_key_phase), 128'd0);
    checkOutput("rst_done", 128'(po_end_of_decryption), 128'd0);
    checkOutput("rst_round", 128'(po_current_round), 128'd0);
    pi_rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] FIPS-197 C.1 vector");
    applyStimulus(KEY_C1, CT_C1);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      checkOutput("c1_done", 128'(po_end_of_decryption), 128'(k == 21));
      if (k <= 20) checkOutput("c1_busy", 128'(po_busy), 128'd1);
      if (k == 5) checkOutput("c1_key_phase_on", 128'(po_key_phase), 128'd1);
      if (k == 10) checkOutput("c1_round_exp_end", 128'(po_current_round), 128'd10);
      if (k == 15) begin
        checkOutput("c1_key_phase_off", 128'(po_key_phase), 128'd0);
        checkOutput("c1_round_mid", 128'(po_current_round), 128'd5);
      end
      if (k == 21) begin
        checkOutput("c1_busy_end", 128'(po_busy), 128'd0);
        checkOutput("c1_pt", po_out, PT_C1);
      end
      if (k == 22) begin
        checkOutput("c1_pt_hold", po_out, PT_C1);
        checkOutput("c1_round_idle", 128'(po_current_round), 128'd0);
      end
    end

    $display("[TB] FIPS-197 appendix B vector");
    applyStimulus(KEY_B, CT_B);
    repeat (10) @(negedge clk);
    checkOutput("b_rk10", dut.key_q, RK10_B);
    waitDone("b", lat);
    checkOutput("b_latency", 128'(lat), 128'd21);
    checkOutput("b_pt", po_out, PT_B);

    $display("[TB] start while busy");
    applyStimulus(KEY_C1, CT_C1);
    dc0 = doneCount;
    repeat (4) @(negedge clk);
    pi_input_key  = KEY_B;
    pi_input_data = CT_B;
    pi_start      = 1'b1;
    @(negedge clk);
    pi_start = 1'b0;
    waitDone("busy_start", lat);
    checkOutput("busy_start_latency", 128'(lat), 128'd21);
    checkOutput("busy_start_pt", po_out, PT_C1);
    repeat (30) @(negedge clk);
    checkOutput("busy_start_done_count", 128'(doneCount - dc0), 128'd1);
    checkOutput("busy_start_idle", 128'(po_busy), 128'd0);

    $display("[TB] reset mid-operation");
    applyStimulus(KEY_C1, CT_C1);
    repeat (11) @(negedge clk);
    dc0 = doneCount;
    @(posedge clk);
    #2;
    pi_rst_n = 1'b0;
    #1;
    checkOutput("midrst_out", po_out, 128'd0);
    checkOutput("midrst_busy", 128'(po_busy), 128'd0);
    checkOutput("midrst_key_phase", 128'(po_key_phase), 128'd0);
    checkOutput("midrst_round", 128'(po_current_round), 128'd0);
    checkOutput("midrst_done", 128'(po_end_of_decryption), 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    pi_rst_n = 1'b1;
    repeat (25) @(negedge clk);
    checkOutput("midrst_no_done", 128'(doneCount - dc0), 128'd0);
    checkOutput("midrst_out_kept_zero", po_out, 128'd0);
    applyStimulus(KEY_C1, CT_C1);
    waitDone("midrst_fresh", lat);
    checkOutput("midrst_fresh_latency", 128'(lat), 128'd21);
    checkOutput("midrst_fresh_pt", po_out, PT_C1);

    $display("[TB] back-to-back");
    applyStimulus(KEY_C1, CT_C1);
    waitDone("b2b_first", lat);
    firstDone = cycleCount;
    checkOutput("b2b_first_pt", po_out, PT_C1);
    applyStimulus(KEY_B, CT_B);
    holdOk     = 1'b1;
    secondDone = -1;
    if (po_out !== PT_C1) holdOk = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (po_end_of_decryption) begin
        secondDone = cycleCount;
        break;
      end
      if (po_out !== PT_C1) holdOk = 1'b0;
    end
    checkOutput("b2b_hold", 128'(holdOk), 128'd1);
    checkOutput("b2b_gap", 128'(secondDone - firstDone), 128'd22);
    checkOutput("b2b_second_pt", po_out, PT_B);

    $display("[TB] random loopback");
    checkOutput("enc_model_c1", aesEncrypt(KEY_C1, PT_C1), CT_C1);
    randBad = badChecks;
    for (int i = 0; i < 1000; i++) begin
      rk = {$urandom(), $urandom(), $urandom(), $urandom()};
      rp = {$urandom(), $urandom(), $urandom(), $urandom()};
      rc = aesEncrypt(rk, rp);
      applyStimulus(rk, rc);
      waitDone("rand", lat);
      checkOutput("rand_pt", po_out, rp);
      if (badChecks - randBad > 5) break;
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/aes_decrypt_block.md
Name: aes_decrypt_block

Overview:
- Iterative AES-128 decryptor, the inverse of the team's encryption block.
- Takes a 128-bit ciphertext and the cipher key, and returns the 128-bit plaintext.
- One round per clock. Round keys are computed on the fly: 10 forward expansion steps reach round key 10, then the schedule is walked backwards during decryption, so no 11-entry key RAM is needed.
- Sits beside the encryptor in the crypto datapath and uses the same start/done style of control.

Parameters:
- NR, 10, number of AES rounds. Fixed for AES-128; any other value is illegal and must be rejected at elaboration.

Ports:
- pi_clk  input  1  clock.
- pi_rst_n  input  1  reset, asynchronous, active-low.
- pi_start  input  1  single-cycle request. Honoured only in IDLE.
- pi_input_key  input  128  cipher key (round key 0). Sampled on the start edge.
- pi_input_data  input  128  ciphertext. Sampled on the start edge.
- po_busy  output  1  high from the cycle after an accepted start until po_done.
- po_key_phase  output  1  high while forward key expansion runs.
- po_current_round  output  4  index of the round key currently in the key register.
- po_end_of_decryption  output  1  one-cycle pulse; po_out is valid from the same cycle.
- po_out  output  128  plaintext, registered. Holds its value until the next completion or reset.

Behaviour:
- Byte order follows FIPS-197: bits [127:120] are byte 0 (s0,0); the state is column-major.
- Reset (pi_rst_n low, asynchronous) clears everything:
  - state goes to IDLE;
  - data, key, round and po_out registers go to 0;
  - po_busy, po_key_phase and po_end_of_decryption go to 0.
- Reset mid-operation aborts the operation silently; no done pulse is produced.
- FSM states are IDLE, KEY_EXP, INIT_ARK, ROUND, FINAL.
- IDLE:
  - Start edge E0: data register <= pi_input_data, key register <= pi_input_key, round <= 0, go to KEY_EXP.
  - pi_start in any other state is ignored and has no side effects.
- KEY_EXP:
  - Each cycle: key <= forward_next(key, rcon[round+1]), round <= round+1.
  - The step taken with round==9 moves the FSM to INIT_ARK.
  - This phase takes exactly 10 cycles.
- INIT_ARK (1 cycle):
  - data <= data ^ key (round key 10).
  - key <= inverse_next(key, rcon[10]), round <= 9.
  - Go to ROUND.
- ROUND (9 cycles, round = 9 down to 1):
  - data <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(data)), key)).
  - key <= inverse_next(key, rcon[round]), round <= round-1.
  - Leave to FINAL when round==1 is processed.
- FINAL (1 cycle):
  - po_out <= AddRoundKey(InvSubBytes(InvShiftRows(data)), key), using key = round key 0.
  - po_end_of_decryption <= 1 for one cycle.
  - Go to IDLE.
- Latency: po_end_of_decryption asserts on edge E0+21. The next start is accepted on the edge where done is asserted +1, i.e. back-to-back every 22 cycles.
- inverse_next is exact algebra, w' = w ^ previous word:
  - w0' = w0 ^ SubWord(RotWord(w3 ^ w2)) ^ rcon
  - w1' = w1 ^ w0
  - w2' = w2 ^ w1
  - w3' = w3 ^ w2
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, in the top byte of the word.
- All arithmetic is in GF(2^8) with polynomial 0x11b. InvMixColumns uses coefficients 0e, 0b, 0d, 09.
- po_current_round is 0 in IDLE and equals the round register otherwise.

Decomposition:
- Package aes_pkg holds:
  - FSM state encoding;
  - rcon table;
  - forward S-box and inverse S-box functions;
  - xtime/gmul functions;
  - forward_next and inverse_next key-step functions.
  The package is shared with the encryptor.
- One combinational sub-module, aes_inv_round (pi_in, pi_key, pi_skip_mix, po_out): InvShiftRows, InvSubBytes, AddRoundKey, then optional InvMixColumns.
- The FSM and the registers stay in aes_decrypt_block.

Test Plan:
- FIPS-197 C.1 vector:
  - stimulus: key 000102030405060708090a0b0c0d0e0f, data 69c4e0d86a7b0430d8cdb78070b4c55a, start;
  - required: po_out = 00112233445566778899aabbccddeeff with done on exactly E0+21; po_busy high for E0+1..E0+20.
- FIPS-197 App. B vector:
  - stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, data 3925841d02dc09fbdc118597196a0b32;
  - required: po_out = 3243f6a8885a308d313198a2e0370734; key register equals d014f9a8c9ee2589e13f0cc8b6630ca6 on entry to INIT_ARK.
- Start while busy:
  - stimulus: second start with different data at E0+5;
  - required: ignored; result is still the first vector's plaintext; exactly one done pulse.
- Reset mid-operation:
  - stimulus: pi_rst_n low at E0+12 for 2 cycles;
  - required: all outputs 0 immediately (asynchronous); no done pulse; a fresh start afterwards gives the C.1 result.
- Back-to-back:
  - stimulus: C.1 then B, with the second start on the cycle after done;
  - required: two correct results 22 cycles apart; po_out holds the first result until the second done.
- Random loopback:
  - stimulus: 1000 random key/plaintext pairs, encrypted with the team's encryptor and then fed here;
  - required: plaintext recovered in every case.
